// File: rtl/c1126_pkg.sv
// rtl/c1126_pkg.sv - shared symbol codes and FSM states for the c1126 3-bit symbol link
package c1126_pkg;

  // Link symbols {in2,in1,in0}
  localparam logic [2:0] SYM_IDLE     = 3'b000;
  localparam logic [2:0] SYM_SOF      = 3'b010;
  localparam logic [2:0] SYM_EOF      = 3'b001;
  // Data and parity symbols carry this tag bit; the low bits are the payload
  localparam logic [2:0] SYM_DATA_TAG = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOF    = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_EOF    = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  // Data symbol: tag bit plus one payload bit pair {d[2k+1], d[2k]}
  function automatic logic [2:0] data_sym(input logic [1:0] pair);
    return SYM_DATA_TAG | {1'b0, pair};
  endfunction

  // Parity symbol: tag bit, a zero, then the parity bit
  function automatic logic [2:0] parity_sym(input logic p);
    return SYM_DATA_TAG | {2'b00, p};
  endfunction

endpackage

// File: rtl/c1126_gap_timer.sv
// rtl/c1126_gap_timer.sv - loadable down-counter with zero flag, shared by data index and idle gap
module c1126_gap_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; the count saturates at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/c1126_sym_tx.sv
// rtl/c1126_sym_tx.sv - c1126 symbol transmitter; optional parity symbol via C1126_SYM_TX_PARITY_EN
module c1126_sym_tx
  import c1126_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [2:0]        sym_out,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int NPAIR   = DATA_W / 2;
  // One counter serves both the data-symbol index and the idle gap
  localparam int TMR_MAX = (NPAIR > GAP_CYCLES) ? NPAIR : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DATA_LOAD = TMR_W'(NPAIR - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? TMR_W'(GAP_CYCLES - 1) : '0;

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [2:0]        sym_next;
  logic              take;
  logic              tmr_load;
  logic              tmr_dec;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_done;
`ifdef C1126_SYM_TX_PARITY_EN
  logic              parity;
`endif

  assign take = data_valid && (state == ST_IDLE);

  c1126_gap_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  // State register; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Frame sequencing: SOF, data pairs, optional parity, EOF, gap
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (data_valid) next_state = ST_SOF;
      ST_SOF:    next_state = ST_DATA;
`ifdef C1126_SYM_TX_PARITY_EN
      ST_DATA:   if (tmr_done) next_state = ST_PARITY;
`else
      ST_DATA:   if (tmr_done) next_state = ST_EOF;
`endif
      ST_PARITY: next_state = ST_EOF;
      ST_EOF:    next_state = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:    if (tmr_done) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Handshake flags, timer control, shift-register update and the symbol of the next state
  always_comb begin
    data_ready = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    tmr_val    = DATA_LOAD;
    shreg_next = shreg;
    case (state)
      ST_IDLE: if (take) shreg_next = data_in;
      ST_SOF:  tmr_load = 1'b1;
      ST_DATA: begin
        tmr_dec    = 1'b1;
        shreg_next = shreg << 2;
      end
      ST_EOF: begin
        tmr_load = 1'b1;
        tmr_val  = GAP_LOAD;
      end
      ST_GAP:  tmr_dec = 1'b1;
      default: ;
    endcase

    // sym_out is registered, so it is built from the state being entered
    sym_next = SYM_IDLE;
    case (next_state)
      ST_SOF:    sym_next = SYM_SOF;
      ST_DATA:   sym_next = data_sym(shreg_next[DATA_W-1 -: 2]);
`ifdef C1126_SYM_TX_PARITY_EN
      ST_PARITY: sym_next = parity_sym(parity);
`endif
      ST_EOF:    sym_next = SYM_EOF;
      default:   sym_next = SYM_IDLE;
    endcase
  end

  // Payload shift register, symbol flop and completed-frame counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      sym_out   <= SYM_IDLE;
      frame_cnt <= '0;
    end else begin
      shreg   <= shreg_next;
      sym_out <= sym_next;
      if (state == ST_EOF) frame_cnt <= frame_cnt + 1'b1;
    end
  end

`ifdef C1126_SYM_TX_PARITY_EN
  // Even parity over the whole word, taken at capture since the shift register is consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity <= 1'b0;
    end else if (take) begin
      parity <= ^data_in;
    end
  end
`endif

endmodule

// File: tb/tb_c1126_sym_tx.sv
// tb/tb_c1126_sym_tx.sv - scoreboard bench for c1126_sym_tx against a frame-level reference model
module tb_c1126_sym_tx;

  localparam int DATA_W     = 4;
  localparam int GAP_CYCLES = 2;
  localparam int CNT_W      = 2;
  localparam int NPAIR      = DATA_W / 2;
`ifdef C1126_SYM_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int PERIOD = NPAIR + 3 + GAP_CYCLES + PAR;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic [2:0]        sym_out;
  logic              busy;
  logic [CNT_W-1:0]  frame_cnt;

  c1126_sym_tx #(
    .DATA_W     (DATA_W),
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .sym_out    (sym_out),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       sym;
    logic [CNT_W-1:0] cnt;
    bit               eof;
  } exp_t;

  exp_t             q[$];
  int               checks = 0;
  int               failures = 0;
  logic [CNT_W-1:0] n_frames = '0;
  logic [CNT_W-1:0] idle_cnt = '0;
  bit               mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the whole symbol sequence of one frame, derived from the framing rules
  task automatic push_frame(input logic [DATA_W-1:0] d);
    exp_t e;
    e.cnt = n_frames;
    e.eof = 1'b0;
    e.sym = 3'b010;
    q.push_back(e);
    for (int k = 0; k < NPAIR; k++) begin
      e.sym = {1'b1, 2'((d >> (DATA_W - 2 - 2 * k)) & 3)};
      q.push_back(e);
    end
`ifdef C1126_SYM_TX_PARITY_EN
    e.sym = {2'b10, ^d};
    q.push_back(e);
`endif
    e.sym = 3'b001;
    e.eof = 1'b1;
    q.push_back(e);
    e.eof = 1'b0;
    n_frames = n_frames + 1'b1;
    e.cnt = n_frames;
    for (int g = 0; g < GAP_CYCLES; g++) begin
      e.sym = 3'b000;
      q.push_back(e);
    end
  endtask

  // Monitor: every busy cycle consumes one expected symbol; idle cycles must be quiet
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst) begin
      if (busy) begin
        if (q.size() == 0) begin
          chk("busy_without_frame", busy, 0);
        end else begin
          e = q.pop_front();
          chk("sym", sym_out, e.sym);
          chk("frame_cnt", frame_cnt, e.cnt);
          chk("ready_while_busy", data_ready, 0);
          if (e.eof) idle_cnt = e.cnt + 1'b1;
        end
      end else begin
        chk("idle_sym", sym_out, 0);
        chk("idle_ready", data_ready, 1);
        chk("idle_frame_cnt", frame_cnt, idle_cnt);
        chk("frame_cut_short", q.size(), 0);
        q.delete();
      end
    end
  end

  // One driver cycle, entered and left at posedge+2
  task automatic cyc(input bit v, input logic [DATA_W-1:0] d, output bit xfer);
    data_valid = v;
    data_in    = d;
    xfer       = v && data_ready;
    @(posedge clk);
    if (xfer) push_frame(d);
    #2;
  endtask

  task automatic drain();
    bit x;
    for (int i = 0; i < 4 * PERIOD && busy; i++) cyc(1'b0, DATA_W'($urandom), x);
    chk("drain_timeout", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit x;
    int last;
    @(posedge clk);
    #2;
    // Reset held with toggling valid
    for (int i = 0; i < 3; i++) begin
      data_valid = ~data_valid;
      data_in    = DATA_W'($urandom);
      @(posedge clk);
      #2;
      chk("rst_sym", sym_out, 0);
      chk("rst_ready", data_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
    end
    data_valid = 1'b0;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Directed frame 4'b1011
    cyc(1'b1, 4'b1011, x);
    chk("directed_accept", x, 1);
    for (int i = 0; i < PERIOD + 1; i++) cyc(1'b0, DATA_W'($urandom), x);

    // Random valid/data
    for (int i = 0; i < 300; i++) cyc(($urandom_range(0, 99) < 40), DATA_W'($urandom), x);
    drain();

    // Valid held high with changing data: back-to-back frames at the nominal period
    last = -1;
    for (int i = 0; i < 80; i++) begin
      cyc(1'b1, DATA_W'($urandom), x);
      if (x) begin
        if (last >= 0) chk("xfer_period", i - last, PERIOD);
        last = i;
      end
    end
    drain();

    // Reset during the second data symbol
    cyc(1'b1, DATA_W'($urandom), x);
    chk("pre_reset_accept", x, 1);
    cyc(1'b0, '0, x);
    cyc(1'b0, '0, x);
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk("midrst_sym", sym_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", data_ready, 1);
    chk("midrst_frame_cnt", frame_cnt, 0);
    q.delete();
    n_frames = '0;
    idle_cnt = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst    = 1'b1;
    mon_en = 1'b1;
    cyc(1'b1, DATA_W'($urandom), x);
    chk("post_reset_accept", x, 1);
    for (int i = 0; i < 40; i++) cyc(($urandom_range(0, 99) < 60), DATA_W'($urandom), x);
    drain();
    cyc(1'b0, '0, x);
    chk("final_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
